avalon_pio_bidir: RTL and testbench

- Parametrised Avalon-MM slave parallel I/O port. Generalises the fixed 8-bit output-only control PIO.
- Adds configurable width, per-bit direction, synchronised input sampling, edge capture with write-1-to-clear, and a maskable level interrupt.
- Sits between the system interconnect and board-level control pins, e.g. audio/video config lines, buttons and status flags.

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_sync_edge.sv | 41 ++++
 rtl/avalon_pio_bidir.sv | 94 +++++++++
 tb/tb_avalon_pio_bidir.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register-map and edge-type encodings for the bidirectional Avalon PIO.
package pio_pkg;

   typedef enum logic [2:0] {
      PIO_ADDR_DATA = 3'd0,
      PIO_ADDR_DIR  = 3'd1,
      PIO_ADDR_MASK = 3'd2,
      PIO_ADDR_EDGE = 3'd3,
      PIO_ADDR_SET  = 3'd4,
      PIO_ADDR_CLR  = 3'd5,
      PIO_ADDR_RSV6 = 3'd6,
      PIO_ADDR_RSV7 = 3'd7
   } pio_addr_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-stage input synchroniser followed by a one-cycle edge detector.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] sync_in,
   output logic [DATA_W-1:0] edge_pulse
);

   logic [SYNC_STAGES-1:0][DATA_W-1:0] chain;
   logic [DATA_W-1:0]                  sync_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain     <= '0;
         sync_prev <= '0;
      end else begin
         chain     <= {chain[SYNC_STAGES-2:0], in_port};
         sync_prev <= sync_in;
      end
   end

   assign sync_in = chain[SYNC_STAGES-1];

   generate
      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
         assign edge_pulse = sync_in & ~sync_prev;
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign edge_pulse = ~sync_in & sync_prev;
      end else begin : g_any
         assign edge_pulse = sync_in ^ sync_prev;
      end
   endgenerate

endmodule

// File: rtl/avalon_pio_bidir.sv
// Avalon-MM bidirectional PIO with edge capture and maskable level irq.
// Define AVALON_PIO_BITOPS_EN to enable the OUTSET/OUTCLR registers at addresses 4/5.
module avalon_pio_bidir
   import pio_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0,
   parameter logic [DATA_W-1:0] DIR_RESET   = '0,
   parameter int                EDGE_TYPE   = EDGE_RISE,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [DATA_W-1:0] oe,
   output logic              irq
);

   logic              wr, rd;
   logic [DATA_W-1:0] wd, mask, edge_cap, edge_clr, rd_val;
   logic [DATA_W-1:0] sync_in, edge_pulse;

   assign wr = chipselect & ~write_n;
   assign rd = chipselect & ~read_n;
   assign wd = writedata[DATA_W-1:0];

   generate
      if (DATA_W < 32) begin : g_wd_hi
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:DATA_W];
      end
   endgenerate

   pio_sync_edge #(
      .DATA_W     (DATA_W),
      .EDGE_TYPE  (EDGE_TYPE),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .sync_in   (sync_in),
      .edge_pulse(edge_pulse)
   );

   assign edge_clr = (wr && address == PIO_ADDR_EDGE) ? wd : '0;

   always_comb begin
      rd_val = '0;
      case (address)
         PIO_ADDR_DATA: rd_val = (sync_in & ~oe) | (out_port & oe);
         PIO_ADDR_DIR:  rd_val = oe;
         PIO_ADDR_MASK: rd_val = mask;
         PIO_ADDR_EDGE: rd_val = edge_cap;
         default:       rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= RESET_VALUE;
         oe       <= DIR_RESET;
         mask     <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr) begin
            case (address)
               PIO_ADDR_DATA: out_port <= wd;
               PIO_ADDR_DIR:  oe       <= wd;
               PIO_ADDR_MASK: mask     <= wd;
`ifdef AVALON_PIO_BITOPS_EN
               PIO_ADDR_SET:  out_port <= out_port | wd;
               PIO_ADDR_CLR:  out_port <= out_port & ~wd;
`endif
               default: ;
            endcase
         end
         // New detections are OR-ed after the clear so a colliding set wins.
         edge_cap <= (edge_cap & ~edge_clr) | edge_pulse;
         irq      <= |(edge_cap & mask);
         if (rd) readdata <= 32'(rd_val);
      end
   end

endmodule

// File: tb/tb_avalon_pio_bidir.sv
// Scoreboard bench for avalon_pio_bidir: reads queue expectations, a monitor checks readdata.
module tb_avalon_pio_bidir;

   localparam int DATA_W = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic        read_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  in_port = '0;
   logic [7:0]  out_port;
   logic [7:0]  oe;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        rd_seen;

   avalon_pio_bidir #(
      .DATA_W     (DATA_W),
      .RESET_VALUE(8'hA5),
      .DIR_RESET  (8'h0F),
      .EDGE_TYPE  (0),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .read_n    (read_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .out_port  (out_port),
      .oe        (oe),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a read strobe registered at a posedge means readdata is valid now.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_seen <= 1'b0;
      else          rd_seen <= chipselect & ~read_n;
   end

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got %h expected no read", readdata);
         end else begin
            check(name_q.pop_front(), readdata, exp_q.pop_front());
         end
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk);
      chipselect = 1'b1; read_n = 1'b0; address = a;
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_readdata_low", readdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_out_port", {24'h0, out_port}, 32'hA5);
      check("rst_oe", {24'h0, oe}, 32'h0F);
      check("rst_irq", {31'h0, irq}, 32'h0);
      bus_read(3'd1, 32'h0000_000F, "rst_rd_dir");
      bus_read(3'd2, 32'h0, "rst_rd_mask");
      bus_read(3'd0, 32'h05, "rst_rd_data");

      // Mixed-direction read; in_port rising bits also land in edge_cap
      bus_write(3'd1, 32'hF0);
      bus_write(3'd0, 32'h3C);
      in_port = 8'h99;
      wait_clks(3);
      bus_read(3'd0, 32'h39, "mixed_rd_data");
      check("mixed_oe", {24'h0, oe}, 32'hF0);
      check("mixed_out_port", {24'h0, out_port}, 32'h3C);
      bus_read(3'd3, 32'h99, "mixed_edge_cap");
      bus_write(3'd3, 32'hFF);
      bus_read(3'd3, 32'h0, "w1c_all");

      // Rising edge on bit 0 with mask, then clear
      in_port = 8'h98;
      wait_clks(4);
      bus_write(3'd3, 32'hFF);
      bus_write(3'd2, 32'h01);
      in_port = 8'h99;
      wait_clks(3);
      check("edge_irq_not_yet", {31'h0, irq}, 32'h0);
      wait_clks(1);
      check("edge_irq_set", {31'h0, irq}, 32'h1);
      bus_read(3'd3, 32'h01, "edge_cap_bit0");
      bus_write(3'd3, 32'h01);
      check("clr_irq_one_clk", {31'h0, irq}, 32'h1);
      wait_clks(1);
      check("clr_irq_two_clk", {31'h0, irq}, 32'h0);

      // Detection on bit 2 collides with a write-1 clear of bit 2
      bus_write(3'd2, 32'h05);
      in_port = 8'h9D;
      wait_clks(1);
      bus_write(3'd3, 32'h04);
      wait_clks(1);
      check("collide_irq", {31'h0, irq}, 32'h1);
      bus_read(3'd3, 32'h04, "collide_edge_cap");
      check("collide_irq_held", {31'h0, irq}, 32'h1);

      // Bit operations and reserved addresses
      bus_write(3'd0, 32'h0F);
      check("bitop_base", {24'h0, out_port}, 32'h0F);
      bus_write(3'd4, 32'h30);
`ifdef AVALON_PIO_BITOPS_EN
      check("bitop_set", {24'h0, out_port}, 32'h3F);
`else
      check("bitop_set", {24'h0, out_port}, 32'h0F);
`endif
      bus_write(3'd5, 32'h03);
`ifdef AVALON_PIO_BITOPS_EN
      check("bitop_clr", {24'h0, out_port}, 32'h3C);
`else
      check("bitop_clr", {24'h0, out_port}, 32'h0F);
`endif
      bus_read(3'd4, 32'h0, "rd_addr4");
      bus_read(3'd5, 32'h0, "rd_addr5");
      bus_read(3'd6, 32'h0, "rd_addr6");
      bus_write(3'd7, 32'hFF);
      bus_write(3'd6, 32'hFF);
      check("rsv_write_ignored_oe", {24'h0, oe}, 32'hF0);
      bus_write(3'd1, 32'hFFFF_FF3C);
      bus_read(3'd1, 32'h0000_003C, "dir_upper_bits_zero");

      // Build edge_cap = 0xFF with irq, then async reset between edges
      bus_write(3'd0, 32'h12);
      bus_write(3'd1, 32'h33);
      bus_write(3'd2, 32'hFF);
      in_port = 8'h00;
      wait_clks(4);
      bus_write(3'd3, 32'hFF);
      in_port = 8'hFF;
      wait_clks(5);
      check("pre_rst_irq", {31'h0, irq}, 32'h1);
      bus_read(3'd3, 32'hFF, "pre_rst_edge_cap");
      in_port = 8'h00;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      #1;
      check("arst_out_port", {24'h0, out_port}, 32'hA5);
      check("arst_oe", {24'h0, oe}, 32'h0F);
      check("arst_irq", {31'h0, irq}, 32'h0);
      check("arst_readdata", readdata, 32'h0);
      bus_read(3'd3, 32'h0, "arst_edge_cap");
      bus_read(3'd2, 32'h0, "arst_mask");

      wait_clks(3);
      check("queue_drain", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
